// File: rtl/ethernet_bus_pkg.sv
// Shared Ethernet lookup types: VLAN, MAC address, port and the lookup request
// record handed from a requester to the MAC address table.
package ethernet_bus_pkg;

  localparam int unsigned VLAN_W = 12;
  localparam int unsigned MAC_W  = 48;
  localparam int unsigned PORT_W = 6;

  typedef logic [VLAN_W-1:0] vlan_t;
  typedef logic [MAC_W-1:0]  macaddr_t;
  typedef logic [PORT_W-1:0] port_t;

  typedef struct packed {
    vlan_t    vlan;
    macaddr_t src_mac;
    port_t    src_port;
    macaddr_t dst_mac;
  } mac_lookup_req_t;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/lookup_tag_fifo.sv
// In-order tag FIFO for lookups in flight. The owner guarantees it never pushes
// when full or pops when empty, so the FIFO keeps only its two pointers.
module lookup_tag_fifo
  import ethernet_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_fabric,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data
);

  localparam int unsigned PTR_W = idx_width(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;

  // Advance a pointer, wrapping at DEPTH without skipping a slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Write side: store the tag and advance the write pointer.
  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      wr_ptr_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= '0;
      end
    end else if (push) begin
      wr_ptr_r        <= ptr_inc(wr_ptr_r);
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read side: advance past the oldest tag once its result is consumed.
  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      rd_ptr_r <= '0;
    end else if (pop) begin
      rd_ptr_r <= ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  assign pop_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/mac_lookup_arbiter.sv
// Round-robin arbiter that funnels per-requester MAC lookups into a single MAC
// table port, bounds the lookups in flight, and routes the in-order results
// back to the requester that issued each lookup.
module mac_lookup_arbiter
  import ethernet_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk_fabric,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][11:0]  req_src_vlan,
  input  logic [NUM_REQ-1:0][47:0]  req_src_mac,
  input  logic [NUM_REQ-1:0][47:0]  req_dst_mac,
  input  logic [NUM_REQ-1:0][5:0]   req_src_port,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_hit,
  output logic [5:0]                resp_dst_port,
  output logic                      tbl_lookup_en,
  output logic [11:0]               tbl_lookup_src_vlan,
  output logic [47:0]               tbl_lookup_src_mac,
  output logic [47:0]               tbl_lookup_dst_mac,
  output logic [5:0]                tbl_lookup_src_port,
  input  logic                      tbl_lookup_done,
  input  logic                      tbl_lookup_hit,
  input  logic [5:0]                tbl_lookup_dst_port,
  output logic                      err_spurious_done
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]   rr_ptr_r;
  logic [CNT_W-1:0]   outstanding_r;
  logic               slot_free_s;
  logic               grant_found_s;
  logic [IDX_W-1:0]   grant_idx_s;
  int                 cand_s;
  logic [IDX_W-1:0]   cand_idx_s;
  logic               transfer_s;
  logic               done_ok_s;
  logic [IDX_W-1:0]   tag_s;
  mac_lookup_req_t    grant_req_s;
  mac_lookup_req_t    tbl_req_r;
  logic               tbl_en_r;
  logic [NUM_REQ-1:0] resp_valid_r;
  logic               resp_hit_r;
  port_t              resp_port_r;
  logic               err_r;

  // Round-robin search from the pointer; a slot must already be free, so a
  // result arriving this cycle only opens a slot from the next cycle on.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = 0;
    cand_idx_s    = '0;
    slot_free_s   = (outstanding_r < CNT_W'(MAX_OUTSTANDING)) && !rst;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = int'(rr_ptr_r) + k;
      if (cand_s >= int'(NUM_REQ)) begin
        cand_s = cand_s - int'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = cand_s[IDX_W-1:0];
      if (slot_free_s && !grant_found_s && req_valid[cand_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_idx_s;
      end else begin
        grant_found_s = grant_found_s;
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // One-hot ready for the single winner of this cycle.
  always_comb begin
    req_ready = '0;
    if (grant_found_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Gather the winner's request fields for the table.
  always_comb begin
    grant_req_s.vlan     = req_src_vlan[grant_idx_s];
    grant_req_s.src_mac  = req_src_mac[grant_idx_s];
    grant_req_s.src_port = req_src_port[grant_idx_s];
    grant_req_s.dst_mac  = req_dst_mac[grant_idx_s];
  end

  assign transfer_s = |(req_valid & req_ready);
  // A result with nothing in flight is ignored apart from the error flag.
  assign done_ok_s  = tbl_lookup_done && (outstanding_r != '0);

  // Round-robin pointer: next search starts just after the last winner.
  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (transfer_s) begin
      if (grant_idx_s == IDX_W'(NUM_REQ - 1)) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= grant_idx_s + IDX_W'(1);
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Lookups in flight: counted at grant so back-to-back grants cannot overrun.
  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      outstanding_r <= '0;
    end else begin
      case ({transfer_s, done_ok_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  lookup_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_tag_fifo (
    .clk_fabric (clk_fabric),
    .rst        (rst),
    .push       (transfer_s),
    .push_data  (grant_idx_s),
    .pop        (done_ok_s),
    .pop_data   (tag_s)
  );

  // Table request: single-cycle strobe with the registered winner fields.
  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      tbl_en_r  <= 1'b0;
      tbl_req_r <= '0;
    end else if (transfer_s) begin
      tbl_en_r  <= 1'b1;
      tbl_req_r <= grant_req_s;
    end else begin
      tbl_en_r  <= 1'b0;
      tbl_req_r <= '0;
    end
  end

  // Result routing: strobe the requester that owns the oldest tag.
  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      resp_valid_r <= '0;
      resp_hit_r   <= 1'b0;
      resp_port_r  <= '0;
    end else if (done_ok_s) begin
      resp_valid_r <= NUM_REQ'(1'b1) << tag_s;
      resp_hit_r   <= tbl_lookup_hit;
      resp_port_r  <= tbl_lookup_dst_port;
    end else begin
      resp_valid_r <= '0;
      resp_hit_r   <= 1'b0;
      resp_port_r  <= '0;
    end
  end

  // Sticky spurious-result flag, cleared only by reset.
  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (tbl_lookup_done && (outstanding_r == '0)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign tbl_lookup_en       = tbl_en_r;
  assign tbl_lookup_src_vlan = tbl_req_r.vlan;
  assign tbl_lookup_src_mac  = tbl_req_r.src_mac;
  assign tbl_lookup_dst_mac  = tbl_req_r.dst_mac;
  assign tbl_lookup_src_port = tbl_req_r.src_port;
  assign resp_valid          = resp_valid_r;
  assign resp_hit            = resp_hit_r;
  assign resp_dst_port       = resp_port_r;
  assign err_spurious_done   = err_r;

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// Directed, table-driven bench for mac_lookup_arbiter: each row drives one
// cycle of requester/table inputs, checks ready combinationally, then checks
// the registered outputs after the clock edge.
module tb_mac_lookup_arbiter;

  logic              clk_fabric = 1'b0;
  logic              rst;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [3:0][11:0]  req_src_vlan;
  logic [3:0][47:0]  req_src_mac;
  logic [3:0][47:0]  req_dst_mac;
  logic [3:0][5:0]   req_src_port;
  logic [3:0]        resp_valid;
  logic              resp_hit;
  logic [5:0]        resp_dst_port;
  logic              tbl_lookup_en;
  logic [11:0]       tbl_lookup_src_vlan;
  logic [47:0]       tbl_lookup_src_mac;
  logic [47:0]       tbl_lookup_dst_mac;
  logic [5:0]        tbl_lookup_src_port;
  logic              tbl_lookup_done;
  logic              tbl_lookup_hit;
  logic [5:0]        tbl_lookup_dst_port;
  logic              err_spurious_done;

  int checks;
  int failures;

  mac_lookup_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(4)) dut (
    .clk_fabric          (clk_fabric),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_src_vlan        (req_src_vlan),
    .req_src_mac         (req_src_mac),
    .req_dst_mac         (req_dst_mac),
    .req_src_port        (req_src_port),
    .resp_valid          (resp_valid),
    .resp_hit            (resp_hit),
    .resp_dst_port       (resp_dst_port),
    .tbl_lookup_en       (tbl_lookup_en),
    .tbl_lookup_src_vlan (tbl_lookup_src_vlan),
    .tbl_lookup_src_mac  (tbl_lookup_src_mac),
    .tbl_lookup_dst_mac  (tbl_lookup_dst_mac),
    .tbl_lookup_src_port (tbl_lookup_src_port),
    .tbl_lookup_done     (tbl_lookup_done),
    .tbl_lookup_hit      (tbl_lookup_hit),
    .tbl_lookup_dst_port (tbl_lookup_dst_port),
    .err_spurious_done   (err_spurious_done)
  );

  always #5 clk_fabric = ~clk_fabric;

  // Requester contract: valid and fields hold until the request is taken.
  for (genvar g = 0; g < 4; g++) begin : g_contract
    a_hold: assert property (@(posedge clk_fabric) disable iff (rst)
      (req_valid[g] && !req_ready[g]) |=>
        (req_valid[g] && $stable(req_src_mac[g]) && $stable(req_dst_mac[g]) &&
         $stable(req_src_vlan[g]) && $stable(req_src_port[g])));
  end

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       done;
    logic       hit;
    logic [5:0] port;
    logic [3:0] ready;
    logic       en;
    logic [1:0] en_idx;
    logic [3:0] resp;
    logic       rhit;
    logic [5:0] rport;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic [3:0] val, input logic d,
                             input logic h, input logic [5:0] p, input logic [3:0] rdy,
                             input logic e, input logic [1:0] ei, input logic [3:0] rv,
                             input logic rh, input logic [5:0] rp, input logic er);
    vec_t x;
    x.rst = r; x.valid = val; x.done = d; x.hit = h; x.port = p;
    x.ready = rdy; x.en = e; x.en_idx = ei; x.resp = rv; x.rhit = rh;
    x.rport = rp; x.err = er;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_tbl_fields(input string name, input int idx);
    chk({name, " vlan"},     64'(tbl_lookup_src_vlan), 64'(req_src_vlan[idx]));
    chk({name, " src_mac"},  64'(tbl_lookup_src_mac),  64'(req_src_mac[idx]));
    chk({name, " dst_mac"},  64'(tbl_lookup_dst_mac),  64'(req_dst_mac[idx]));
    chk({name, " src_port"}, 64'(tbl_lookup_src_port), 64'(req_src_port[idx]));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // A: single requester 2, table answers one cycle after en.
    vecs.push_back(v(1'b0, 4'b0100, 1'b0, 1'b0, 6'd0,  4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 1'b1, 6'd7,  4'b0000, 1'b0, 2'd0, 4'b0100, 1'b1, 6'd7,  1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b1, 4'b0000, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    // B: all requesters busy, strict 0,1,2,3 rotation, FIFO wraps.
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 1'b0, 6'd0,  4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 1'b0, 6'd0,  4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 1'b1, 6'd20, 4'b0100, 1'b1, 2'd2, 4'b0001, 1'b1, 6'd20, 1'b0));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 1'b0, 6'd21, 4'b1000, 1'b1, 2'd3, 4'b0010, 1'b0, 6'd21, 1'b0));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 1'b1, 6'd22, 4'b0001, 1'b1, 2'd0, 4'b0100, 1'b1, 6'd22, 1'b0));
    vecs.push_back(v(1'b0, 4'b1111, 1'b1, 1'b0, 6'd23, 4'b0010, 1'b1, 2'd1, 4'b1000, 1'b0, 6'd23, 1'b0));
    vecs.push_back(v(1'b0, 4'b1101, 1'b1, 1'b1, 6'd24, 4'b0100, 1'b1, 2'd2, 4'b0001, 1'b1, 6'd24, 1'b0));
    vecs.push_back(v(1'b0, 4'b1001, 1'b1, 1'b0, 6'd25, 4'b1000, 1'b1, 2'd3, 4'b0010, 1'b0, 6'd25, 1'b0));
    vecs.push_back(v(1'b0, 4'b0001, 1'b1, 1'b1, 6'd26, 4'b0001, 1'b1, 2'd0, 4'b0100, 1'b1, 6'd26, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 1'b0, 6'd27, 4'b0000, 1'b0, 2'd0, 4'b1000, 1'b0, 6'd27, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 1'b1, 6'd28, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 6'd28, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    // C: table silent, six requests, stall at four, one result frees one grant.
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 1'b0, 6'd0,  4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b1101, 1'b0, 1'b0, 6'd0,  4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b1001, 1'b0, 1'b0, 6'd0,  4'b1000, 1'b1, 2'd3, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b0001, 1'b0, 1'b0, 6'd0,  4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b0110, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b0110, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b0110, 1'b1, 1'b1, 6'd40, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b1, 6'd40, 1'b0));
    vecs.push_back(v(1'b0, 4'b0110, 1'b0, 1'b0, 6'd0,  4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b0100, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b0100, 1'b1, 1'b0, 6'd41, 4'b0000, 1'b0, 2'd0, 4'b0100, 1'b0, 6'd41, 1'b0));
    vecs.push_back(v(1'b0, 4'b0100, 1'b1, 1'b1, 6'd42, 4'b0100, 1'b1, 2'd2, 4'b1000, 1'b1, 6'd42, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 1'b1, 6'd43, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 6'd43, 1'b0));
    // D: issue and result together at two in flight; result goes to oldest tag.
    vecs.push_back(v(1'b0, 4'b1000, 1'b1, 1'b0, 6'd44, 4'b1000, 1'b1, 2'd3, 4'b0010, 1'b0, 6'd44, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 1'b1, 6'd45, 4'b0000, 1'b0, 2'd0, 4'b0100, 1'b1, 6'd45, 1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 1'b1, 6'd46, 4'b0000, 1'b0, 2'd0, 4'b1000, 1'b1, 6'd46, 1'b0));
    // E: spurious result with nothing in flight; flag stays set.
    vecs.push_back(v(1'b0, 4'b0000, 1'b1, 1'b1, 6'd47, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b1));
    // F: three in flight, reset, then rotation restarts at requester 0.
    vecs.push_back(v(1'b0, 4'b0001, 1'b0, 1'b0, 6'd0,  4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b1));
    vecs.push_back(v(1'b0, 4'b0010, 1'b0, 1'b0, 6'd0,  4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 6'd0,  1'b1));
    vecs.push_back(v(1'b0, 4'b0100, 1'b0, 1'b0, 6'd0,  4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 6'd0,  1'b1));
    vecs.push_back(v(1'b0, 4'b0000, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b1));
    vecs.push_back(v(1'b1, 4'b0000, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b1111, 1'b0, 1'b0, 6'd0,  4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b1110, 1'b0, 1'b0, 6'd0,  4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b1100, 1'b0, 1'b0, 6'd0,  4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b1000, 1'b0, 1'b0, 6'd0,  4'b1000, 1'b1, 2'd3, 4'b0000, 1'b0, 6'd0,  1'b0));
    vecs.push_back(v(1'b0, 4'b0000, 1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  1'b0));

    // Per-requester request fields, constant for the whole run.
    for (int i = 0; i < 4; i++) begin
      req_src_vlan[i] = 12'd10 + 12'(i);
      req_src_mac[i]  = 48'h0a00_0000_0000 | 48'(i);
      req_dst_mac[i]  = 48'hffff_0000_0000 | 48'(i);
      req_src_port[i] = 6'd1 + 6'(i);
    end
    req_src_vlan[2] = 12'd5;
    req_src_mac[2]  = 48'h02_00_00_00_00_01;

    rst                 = 1'b1;
    req_valid           = 4'b0000;
    tbl_lookup_done     = 1'b0;
    tbl_lookup_hit      = 1'b0;
    tbl_lookup_dst_port = 6'd0;

    repeat (3) @(posedge clk_fabric);
    #2;
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_hit", 64'(resp_hit), 64'd0);
    chk("reset resp_dst_port", 64'(resp_dst_port), 64'd0);
    chk("reset tbl_lookup_en", 64'(tbl_lookup_en), 64'd0);
    chk("reset tbl_vlan", 64'(tbl_lookup_src_vlan), 64'd0);
    chk("reset tbl_src_mac", 64'(tbl_lookup_src_mac), 64'd0);
    chk("reset tbl_dst_mac", 64'(tbl_lookup_dst_mac), 64'd0);
    chk("reset tbl_src_port", 64'(tbl_lookup_src_port), 64'd0);
    chk("reset err_spurious_done", 64'(err_spurious_done), 64'd0);
    req_valid = 4'b1111;
    #1;
    chk("reset req_ready gated", 64'(req_ready), 64'd0);
    req_valid = 4'b0000;
    @(posedge clk_fabric);
    #2;

    for (int i = 0; i < vecs.size(); i++) begin
      rst                 = vecs[i].rst;
      req_valid           = vecs[i].valid;
      tbl_lookup_done     = vecs[i].done;
      tbl_lookup_hit      = vecs[i].hit;
      tbl_lookup_dst_port = vecs[i].port;
      #1;
      chk($sformatf("row%0d req_ready", i), 64'(req_ready), 64'(vecs[i].ready));
      @(posedge clk_fabric);
      #2;
      chk($sformatf("row%0d tbl_lookup_en", i), 64'(tbl_lookup_en), 64'(vecs[i].en));
      if (vecs[i].en) begin
        chk_tbl_fields($sformatf("row%0d tbl", i), int'(vecs[i].en_idx));
      end
      chk($sformatf("row%0d resp_valid", i), 64'(resp_valid), 64'(vecs[i].resp));
      if (vecs[i].resp != 4'b0000) begin
        chk($sformatf("row%0d resp_hit", i), 64'(resp_hit), 64'(vecs[i].rhit));
        chk($sformatf("row%0d resp_dst_port", i), 64'(resp_dst_port), 64'(vecs[i].rport));
      end
      chk($sformatf("row%0d err_spurious_done", i), 64'(err_spurious_done), 64'(vecs[i].err));
    end

    // Full table after the refill: requester 2 waits while results are absent.
    tbl_lookup_done = 1'b0;
    req_valid       = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("full wait%0d req_ready", c), 64'(req_ready), 64'd0);
      @(posedge clk_fabric);
      #2;
      chk($sformatf("full wait%0d tbl_lookup_en", c), 64'(tbl_lookup_en), 64'd0);
      chk($sformatf("full wait%0d resp_valid", c), 64'(resp_valid), 64'd0);
    end
    // Result arrives: slot is not usable in the same cycle, oldest tag is requester 0.
    tbl_lookup_done     = 1'b1;
    tbl_lookup_hit      = 1'b1;
    tbl_lookup_dst_port = 6'd50;
    #1;
    chk("full done same-cycle req_ready", 64'(req_ready), 64'd0);
    @(posedge clk_fabric);
    #2;
    chk("full done resp_valid", 64'(resp_valid), 64'b0001);
    chk("full done resp_dst_port", 64'(resp_dst_port), 64'd50);
    tbl_lookup_done = 1'b0;
    #1;
    chk("freed slot req_ready", 64'(req_ready), 64'b0100);
    @(posedge clk_fabric);
    #2;
    chk("freed slot tbl_lookup_en", 64'(tbl_lookup_en), 64'd1);
    chk_tbl_fields("freed slot tbl", 2);
    req_valid = 4'b0000;
    @(posedge clk_fabric);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
